// File: rtl/uart_send_if.sv
// uart_send_if: host-side handshake bundle for the multi-byte UART transmitter.
// Ports: en/start/data travel host -> transmitter; tx/busy/done travel back.
// master = host result logic, slave = uart_send.
interface uart_send_if #(
  parameter int DATA_W = 32
);
  logic              en;     // block enable; low aborts and holds idle
  logic              start;  // one-cycle send request
  logic [DATA_W-1:0] data;   // word to send, sampled on acceptance only
  logic              tx;     // serial line, idle high
  logic              busy;   // word transfer in progress
  logic              done;   // one-cycle pulse after the last stop bit

  modport master (
    output en, start, data,
    input  tx, busy, done
  );

  modport slave (
    input  en, start, data,
    output tx, busy, done
  );
endinterface

// File: rtl/uart_send.sv
// uart_send: serialises a BYTE_N-byte word as back-to-back 8N1 frames, MSB byte first, LSB bit first.
// Latency: tx falls one clock after start is sampled; word lasts BYTE_N*10*BAUD_DIV clocks, then done pulses.
// Backpressure: start is ignored while busy (no queueing); en=0 aborts the transfer on the next edge.
// Ports: clk, rst_n (async active-low), bus (uart_send_if.slave: en, start, data in; tx, busy, done out).
module uart_send #(
  parameter int BYTE_N   = 4,
  parameter int DATA_W   = BYTE_N * 8,
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_send_if.slave bus
);

  localparam int CNT_W  = $clog2(BAUD_DIV);
  localparam int BYTE_W = (BYTE_N > 1) ? $clog2(BYTE_N) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  baud_q;
  logic [2:0]        bit_q;
  logic [BYTE_W-1:0] byte_q;
  // word_q always holds the byte being sent in its top 8 bits; it shifts
  // left by one byte at the end of every non-final stop bit.
  logic [DATA_W-1:0] word_q;
  // Remaining data bits 7..1 of the current byte; bit 0 goes straight to tx.
  logic [6:0]        shift_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;

  logic              baud_last;

  assign baud_last = (baud_q == CNT_W'(BAUD_DIV - 1));

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!bus.en) begin
        // Abort: drop the partial frame immediately, never report done.
        state_q <= IDLE;
        baud_q  <= '0;
        tx_q    <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              word_q  <= bus.data;
              byte_q  <= '0;
              baud_q  <= '0;
              tx_q    <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= START;
            end
          end

          START: begin
            if (baud_last) begin
              baud_q  <= '0;
              bit_q   <= '0;
              tx_q    <= word_q[DATA_W-8];
              shift_q <= word_q[DATA_W-1 -: 7];
              state_q <= DATA;
            end else begin
              baud_q <= baud_q + CNT_W'(1);
            end
          end

          DATA: begin
            if (baud_last) begin
              baud_q <= '0;
              if (bit_q == 3'd7) begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end else begin
                bit_q   <= bit_q + 3'd1;
                tx_q    <= shift_q[0];
                shift_q <= shift_q >> 1;
              end
            end else begin
              baud_q <= baud_q + CNT_W'(1);
            end
          end

          STOP: begin
            if (baud_last) begin
              baud_q <= '0;
              if (byte_q == BYTE_W'(BYTE_N - 1)) begin
                tx_q    <= 1'b1;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                // Next start bit follows the stop bit with no idle gap.
                byte_q  <= byte_q + BYTE_W'(1);
                word_q  <= word_q << 8;
                tx_q    <= 1'b0;
                state_q <= START;
              end
            end else begin
              baud_q <= baud_q + CNT_W'(1);
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_send.sv
// tb_uart_send: directed bench for uart_send with BAUD_DIV=10.
// Two instances: a 4-byte word transmitter and a 1-byte variant.
// Expected line levels come from a frame model indexed by clock offset.
module tb_uart_send;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_send_if #(.DATA_W(32)) ifa ();
  uart_send_if #(.DATA_W(8))  ifb ();

  uart_send #(.BYTE_N(4), .CLK_FREQ(1000000), .BAUD(100000)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  uart_send #(.BYTE_N(1), .CLK_FREQ(1000000), .BAUD(100000)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line level c clocks after the first start-bit edge of a word (BAUD_DIV=10).
  function automatic logic exp_tx(input logic [31:0] w, input int nbytes, input int c);
    int          b;
    int          bi;
    logic [31:0] s;
    b  = c / 100;
    bi = (c % 100) / 10;
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    s = w >> ((nbytes - 1 - b) * 8);
    return s[bi - 1];
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if (ifa.tx !== 1'b1 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_a got tx=%b busy=%b done=%b want 1/0/0", ifa.tx, ifa.busy, ifa.done);
    end
    checks++;
    if (ifb.tx !== 1'b1 || ifb.busy !== 1'b0 || ifb.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_b got tx=%b busy=%b done=%b want 1/0/0", ifb.tx, ifb.busy, ifb.done);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if (ifa.tx !== 1'b1 || ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got tx=%b busy=%b want 1/0", ifa.tx, ifa.busy);
    end
  endtask

  task automatic test_basic();
    logic [31:0] w;
    logic [31:0] dec;
    w   = 32'hA5C33C5A;
    dec = '0;
    ifa.data  = w;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (ifa.tx !== exp_tx(w, 4, c)) begin
        errors++;
        $display("FAIL basic_tx c=%0d got=%b want=%b", c, ifa.tx, exp_tx(w, 4, c));
      end
      checks++;
      if (ifa.busy !== 1'b1 || ifa.done !== 1'b0) begin
        errors++;
        $display("FAIL basic_busy c=%0d got busy=%b done=%b want 1/0", c, ifa.busy, ifa.done);
      end
      if ((c % 100) >= 10 && (c % 100) < 90 && (c % 10) == 5)
        dec[(3 - c / 100) * 8 + (c % 100) / 10 - 1] = ifa.tx;
      tick();
    end
    checks++;
    if (ifa.done !== 1'b1 || ifa.busy !== 1'b0 || ifa.tx !== 1'b1) begin
      errors++;
      $display("FAIL basic_done got done=%b busy=%b tx=%b want 1/0/1", ifa.done, ifa.busy, ifa.tx);
    end
    tick();
    checks++;
    if (ifa.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse got done=%b want 0", ifa.done);
    end
    checks++;
    if (dec !== w) begin
      errors++;
      $display("FAIL basic_decode got=%h want=%h", dec, w);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] dec;
    w1  = 32'h0F0F0F0F;
    w2  = 32'h01020304;
    dec = '0;
    ifa.data  = w1;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (ifa.tx !== exp_tx(w1, 4, c)) begin
        errors++;
        $display("FAIL b2b_first_tx c=%0d got=%b want=%b", c, ifa.tx, exp_tx(w1, 4, c));
      end
      tick();
    end
    checks++;
    if (ifa.done !== 1'b1 || ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_done got done=%b busy=%b want 1/0", ifa.done, ifa.busy);
    end
    // New request issued during the done cycle.
    ifa.data  = w2;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (ifa.tx !== exp_tx(w2, 4, c)) begin
        errors++;
        $display("FAIL b2b_second_tx c=%0d got=%b want=%b", c, ifa.tx, exp_tx(w2, 4, c));
      end
      checks++;
      if (ifa.busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_second_busy c=%0d got=%b want=1", c, ifa.busy);
      end
      if ((c % 100) >= 10 && (c % 100) < 90 && (c % 10) == 5)
        dec[(3 - c / 100) * 8 + (c % 100) / 10 - 1] = ifa.tx;
      tick();
    end
    checks++;
    if (ifa.done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_done got=%b want=1", ifa.done);
    end
    checks++;
    if (dec !== w2) begin
      errors++;
      $display("FAIL b2b_decode got=%h want=%h", dec, w2);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    logic [31:0] w;
    int          dones;
    w     = 32'h3C5AA5C3;
    dones = 0;
    ifa.data  = w;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (ifa.tx !== exp_tx(w, 4, c)) begin
        errors++;
        $display("FAIL busy_start_tx c=%0d got=%b want=%b", c, ifa.tx, exp_tx(w, 4, c));
      end
      if (c == 150) begin
        ifa.data  = 32'hFFFFFFFF;
        ifa.start = 1'b1;
      end else begin
        ifa.start = 1'b0;
      end
      tick();
    end
    for (int c = 0; c < 30; c++) begin
      if (ifa.done === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL busy_start_dones got=%0d want=1", dones);
    end
    checks++;
    if (ifa.busy !== 1'b0 || ifa.tx !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_idle got busy=%b tx=%b want 0/1", ifa.busy, ifa.tx);
    end
  endtask

  task automatic test_abort();
    logic [31:0] w;
    logic [31:0] w2;
    w  = 32'hDEADBEEF;
    w2 = 32'h5A3CC3A5;
    ifa.data  = w;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      checks++;
      if (ifa.tx !== exp_tx(w, 4, c)) begin
        errors++;
        $display("FAIL abort_tx c=%0d got=%b want=%b", c, ifa.tx, exp_tx(w, 4, c));
      end
      if (c == 199) ifa.en = 1'b0;
      tick();
    end
    checks++;
    if (ifa.tx !== 1'b1 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_edge got tx=%b busy=%b done=%b want 1/0/0", ifa.tx, ifa.busy, ifa.done);
    end
    // Start while disabled must be ignored.
    ifa.start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      ifa.start = 1'b0;
      checks++;
      if (ifa.tx !== 1'b1 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle c=%0d got tx=%b busy=%b done=%b want 1/0/0", c, ifa.tx, ifa.busy, ifa.done);
      end
    end
    ifa.en = 1'b1;
    tick();
    ifa.data  = w2;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (ifa.tx !== exp_tx(w2, 4, c) || ifa.done !== 1'b0) begin
        errors++;
        $display("FAIL abort_fresh_tx c=%0d got tx=%b done=%b want tx=%b done=0", c, ifa.tx, ifa.done, exp_tx(w2, 4, c));
      end
      tick();
    end
    checks++;
    if (ifa.done !== 1'b1 || ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_fresh_done got done=%b busy=%b want 1/0", ifa.done, ifa.busy);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    logic [31:0] w2;
    w  = 32'h69E17B28;
    w2 = 32'hC0FFEE11;
    ifa.data  = w;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int c = 0; c <= 55; c++) begin
      checks++;
      if (ifa.tx !== exp_tx(w, 4, c)) begin
        errors++;
        $display("FAIL rstmid_tx c=%0d got=%b want=%b", c, ifa.tx, exp_tx(w, 4, c));
      end
      if (c < 55) tick();
    end
    // Between clock edges: reset must act without waiting for clk.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ifa.tx !== 1'b1 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got tx=%b busy=%b done=%b want 1/0/0", ifa.tx, ifa.busy, ifa.done);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if (ifa.tx !== 1'b1 || ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_release got tx=%b busy=%b want 1/0", ifa.tx, ifa.busy);
    end
    ifa.data  = w2;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (ifa.tx !== exp_tx(w2, 4, c)) begin
        errors++;
        $display("FAIL rstmid_fresh_tx c=%0d got=%b want=%b", c, ifa.tx, exp_tx(w2, 4, c));
      end
      tick();
    end
    checks++;
    if (ifa.done !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_fresh_done got=%b want=1", ifa.done);
    end
    tick();
  endtask

  task automatic test_byte1();
    ifb.data  = 8'h00;
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      checks++;
      if (ifb.tx !== exp_tx(32'h0, 1, c)) begin
        errors++;
        $display("FAIL byte1_tx c=%0d got=%b want=%b", c, ifb.tx, exp_tx(32'h0, 1, c));
      end
      checks++;
      if (ifb.busy !== 1'b1 || ifb.done !== 1'b0) begin
        errors++;
        $display("FAIL byte1_busy c=%0d got busy=%b done=%b want 1/0", c, ifb.busy, ifb.done);
      end
      tick();
    end
    checks++;
    if (ifb.done !== 1'b1 || ifb.busy !== 1'b0 || ifb.tx !== 1'b1) begin
      errors++;
      $display("FAIL byte1_done got done=%b busy=%b tx=%b want 1/0/1", ifb.done, ifb.busy, ifb.tx);
    end
    tick();
    checks++;
    if (ifb.done !== 1'b0) begin
      errors++;
      $display("FAIL byte1_done_pulse got=%b want=0", ifb.done);
    end
  endtask

  initial begin
    ifa.en    = 1'b1;
    ifa.start = 1'b0;
    ifa.data  = '0;
    ifb.en    = 1'b1;
    ifb.start = 1'b0;
    ifb.data  = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_while_busy();
    test_abort();
    test_reset_mid();
    test_byte1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_send.md
Name: uart_send

Overview:
- Multi-byte UART transmitter. It is the sending counterpart of the multi-byte receive path.
- Latches a BYTE_N-byte word and serialises it as BYTE_N back-to-back 8N1 frames on tx.
- Byte order: most significant byte first. Bit order within a byte: LSB first.
- A receiver that fills its word from the top byte downward reconstructs the identical word.
- Sits between the host-side result logic (e.g. classification output registers) and the board UART pin.

Parameters:
- BYTE_N, 4, number of bytes per word; legal range 1..16.
- DATA_W, BYTE_N*8, input word width (derived; not to be overridden independently).
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- BAUD_DIV, CLK_FREQ/BAUD (integer truncation), clocks per bit; must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  block enable; low aborts any transfer and holds the block idle.
- start  input  1  one-cycle request to send data; sampled only when busy==0 and en==1.
- data  input  DATA_W  word to send; sampled on the accepting edge only.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a word transfer is in progress.
- done  output  1  one-cycle pulse when the last stop bit of the word has completed.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - tx=1, busy=0, done=0.
  - All counters and the shift register cleared.
  - FSM goes to IDLE.
  - Applies at any point, including mid-frame; no partial frame resumes after reset.
- All outputs are registered.
- FSM states:
  - IDLE: tx=1, busy=0. On start && en, latch data into word register, clear byte counter, go to START.
  - START: tx=0 for BAUD_DIV clocks, then go to DATA with bit counter=0.
  - DATA: tx = current byte bit[bit_cnt] for BAUD_DIV clocks per bit. After bit 7 go to STOP.
  - STOP: tx=1 for BAUD_DIV clocks. At its end:
    - if byte_cnt==BYTE_N-1, go to IDLE and pulse done;
    - otherwise increment byte_cnt and go straight to START (no idle gap between bytes).
- Current byte = word[(BYTE_N-1-byte_cnt)*8 +: 8].
- Baud counter:
  - counts 0..BAUD_DIV-1 and wraps;
  - resets to 0 on every state entry from IDLE;
  - bit advance occurs on the cycle where count==BAUD_DIV-1.
- Latency and timing:
  - start accepted on edge k: tx=0 and busy=1 from edge k+1.
  - Each frame is exactly 10*BAUD_DIV clocks.
  - The word takes BYTE_N*10*BAUD_DIV clocks.
  - done=1 and busy=0 both from edge k+1+BYTE_N*10*BAUD_DIV, for exactly one cycle of done.
- start while busy==1 is ignored; there is no queueing.
- start on the cycle done is high is accepted, since busy is already 0; the next start bit follows with no gap.
- Changes on data after acceptance have no effect on the transfer in progress.
- en=0 in IDLE: start is ignored.
- en=0 while busy:
  - next edge: FSM to IDLE, tx=1, busy=0, done stays 0;
  - the truncated frame is not completed.
- start and en are both assumed synchronous to clk.

Test Plan:
(CLK_FREQ=1000000, BAUD=100000 so BAUD_DIV=10; BYTE_N=4.)
- Basic word: data=32'hA5C33C5A, start pulse in idle -> 4 frames, 400 clocks total.
  - Frame 1 data bits 1,0,1,0,0,1,0,1 (0xA5); then 0xC3, 0x3C, 0x5A.
  - Each frame has start=0 and stop=1.
  - done pulses once at clock 401 after the accepting edge; a bench UART decoder reassembles 0xA5C33C5A.
- Back-to-back: second start (data=32'h01020304) on the done cycle -> tx falls on the next edge with no idle high gap; bytes decode 01,02,03,04.
- Start while busy: extra start with data=32'hFFFFFFFF at clock 150 -> ignored; the original word still transmitted; only one done.
- Abort: en driven 0 at clock 200 -> tx=1 and busy=0 on the next edge; done never asserted; a new start with en=1 sends a complete fresh word.
- Async reset mid-byte: rst_n low for 3 clocks at clock 55 -> tx=1, busy=0 immediately (not clock-aligned); after release, a start sends a full 4-byte word correctly.
- BYTE_N=1, data=8'h00 -> single frame: start bit plus 8 zero bits (tx low 90 clocks), stop high 10 clocks; done at clock 101.
